// File: rtl/instr_encoder_if.sv
// Field-bundle input channel, encoded-word output channel and status for instr_encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              done;
  logic              err;
  logic [ERR_W-1:0]  err_count;

  // encoder side
  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_last, done, err, err_count
  );

  // producer / loader side
  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_last, done, err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I encoder (R-type, LW, SW, BEQ): packs field bundles into 32-bit words,
// tags each with a word address and queues them in a first-word-fall-through FIFO.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 8
) (
  input  logic clk,
  input  logic rst,
  instr_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_q, err_d, done_q, done_d;

  logic [31:0] enc;
  logic        legal;
  logic        in_ready, in_fire, push, pop, out_valid;
  logic [12:0] imm;
  entry_t      head;

  assign imm       = bus.in_imm;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  // Full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready  = !rst && (count_q < CNT_W'(DEPTH));
  assign in_fire   = bus.in_valid && in_ready;
  assign push      = in_fire && legal;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  // Empty FIFO presents the reset values rather than a stale entry.
  assign bus.out_instr = out_valid ? head.instr : '0;
  assign bus.out_addr  = out_valid ? head.addr  : BASE;
  assign bus.out_last  = out_valid && head.last;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

  // Field packing and immediate legality for the selected kind.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (bus.in_kind)
      2'd0: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
      2'd1: begin
        enc   = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
        legal = (imm[12] == imm[11]);
      end
      2'd2: begin
        enc   = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
        legal = (imm[12] == imm[11]);
      end
      default: begin
        enc   = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        legal = !imm[0];
      end
    endcase
  end

  // Next-state: FIFO pointers/storage, address counter, error and done pulses.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{instr: enc, addr: addr_q, last: bus.in_last};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    // A last bundle ends the program whether it was accepted or rejected.
    if (in_fire) begin
      if (bus.in_last) addr_d = BASE;
      else if (legal)  addr_d = addr_q + ADDR_W'(1);
    end
    err_d = in_fire && !legal;
    if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    done_d = pop && head.last;
  end

  // FIFO storage carries no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO backpressure, legality,
// error saturation, address wrap (ADDR_W=2 instance) and async reset.
module tb_instr_encoder;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  instr_encoder_if #(.ADDR_W(10), .ERR_W(8)) ifa ();
  instr_encoder_if #(.ADDR_W(2),  .ERR_W(8)) ifb ();

  instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a bundle at a falling edge, hold until accepted; returns at the falling edge after fire.
  task automatic push_a(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic last);
    int n;
    ifa.in_kind = kind; ifa.in_rd = rd; ifa.in_rs1 = rs1; ifa.in_rs2 = rs2;
    ifa.in_funct3 = f3; ifa.in_funct7 = f7; ifa.in_imm = imm; ifa.in_last = last;
    ifa.in_valid = 1'b1;
    n = 0;
    while (ifa.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL push_timeout observed=in_ready_low expected=accept");
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  // Check the head word, then pop it with a one-cycle out_ready pulse.
  task automatic pop_check(input string tag, input logic [31:0] instr, input logic [9:0] addr,
                           input logic last);
    chk({tag, "_valid"}, ifa.out_valid, 1'b1);
    chk({tag, "_instr"}, ifa.out_instr, instr);
    chk({tag, "_addr"},  ifa.out_addr,  addr);
    chk({tag, "_last"},  ifa.out_last,  last);
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
  endtask

  // R-type ADD rd=k, rs1=1, rs2=2
  function automatic logic [31:0] r_word(input int k);
    return 32'h00208033 | (32'(k) << 7);
  endfunction

  logic [1:0] t5_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1;
    ifa.in_valid = 0; ifa.in_kind = 0; ifa.in_rd = 0; ifa.in_rs1 = 0; ifa.in_rs2 = 0;
    ifa.in_funct3 = 0; ifa.in_funct7 = 0; ifa.in_imm = 0; ifa.in_last = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_kind = 0; ifb.in_rd = 0; ifb.in_rs1 = 1; ifb.in_rs2 = 2;
    ifb.in_funct3 = 0; ifb.in_funct7 = 0; ifb.in_imm = 0; ifb.in_last = 0; ifb.out_ready = 1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready",  ifa.in_ready,  1'b0);
    chk("rst_out_valid", ifa.out_valid, 1'b0);
    chk("rst_out_instr", ifa.out_instr, 32'h0);
    chk("rst_out_addr",  ifa.out_addr,  10'd0);
    chk("rst_err_count", ifa.err_count, 8'd0);
    chk("rst_done_err",  {ifa.done, ifa.err, ifa.out_last}, 3'b000);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", ifa.in_ready, 1'b1);
    @(negedge clk);

    // T1: single R ADD, visible the cycle after acceptance
    ifa.out_ready = 1'b1;
    push_a(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1);
    chk("t1_valid", ifa.out_valid, 1'b1);
    chk("t1_instr", ifa.out_instr, 32'h002081B3);
    chk("t1_addr",  ifa.out_addr,  10'd0);
    chk("t1_last",  ifa.out_last,  1'b1);
    @(negedge clk);
    ifa.out_ready = 1'b0;
    chk("t1_done",  ifa.done, 1'b1);
    chk("t1_empty", ifa.out_valid, 1'b0);

    // T2: LW, SW, BEQ program
    push_a(2'd1, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 1'b0);
    push_a(2'd2, 5'd0, 5'd2, 5'd5, 3'd0, 7'd0, 13'd12, 1'b0);
    push_a(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1);
    chk("t2_no_done", ifa.done, 1'b0);
    pop_check("t2_lw",  32'h00812283, 10'd0, 1'b0);
    pop_check("t2_sw",  32'h00512623, 10'd1, 1'b0);
    chk("t2_no_done_mid", ifa.done, 1'b0);
    pop_check("t2_beq", 32'hFE208EE3, 10'd2, 1'b1);
    chk("t2_done", ifa.done, 1'b1);
    @(negedge clk);
    chk("t2_done_pulse", ifa.done, 1'b0);
    push_a(2'd0, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1);
    pop_check("t2_next", r_word(7), 10'd0, 1'b1);

    // T3: backpressure with a 4-deep FIFO
    for (int k = 0; k < 4; k++) push_a(2'd0, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    chk("t3_full_ready", ifa.in_ready, 1'b0);
    ifa.in_rd = 5'd4; ifa.in_last = 1'b0; ifa.in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_hold_ready", ifa.in_ready, 1'b0);
      chk("t3_hold_instr", ifa.out_instr, r_word(0));
      chk("t3_hold_addr",  ifa.out_addr, 10'd0);
    end
    ifa.in_valid = 1'b0;
    pop_check("t3_w0", r_word(0), 10'd0, 1'b0);
    pop_check("t3_w1", r_word(1), 10'd1, 1'b0);
    push_a(2'd0, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    push_a(2'd0, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    pop_check("t3_w2", r_word(2), 10'd2, 1'b0);
    pop_check("t3_w3", r_word(3), 10'd3, 1'b0);
    pop_check("t3_w4", r_word(4), 10'd4, 1'b0);
    pop_check("t3_w5", r_word(5), 10'd5, 1'b0);

    // T4: illegal immediates
    push_a(2'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'h0800, 1'b0);
    chk("t4_err1",     ifa.err, 1'b1);
    chk("t4_nopush1",  ifa.out_valid, 1'b0);
    chk("t4_errcnt1",  ifa.err_count, 8'd1);
    @(negedge clk);
    chk("t4_err_pulse", ifa.err, 1'b0);
    push_a(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3, 1'b0);
    chk("t4_err2",     ifa.err, 1'b1);
    chk("t4_nopush2",  ifa.out_valid, 1'b0);
    chk("t4_errcnt2",  ifa.err_count, 8'd2);
    push_a(2'd0, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1);
    pop_check("t4_addr_kept", r_word(9), 10'd6, 1'b1);
    // rejected last bundle: err, no done, counter reloads
    push_a(2'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    push_a(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd1, 1'b1);
    chk("t4_rej_last_err",  ifa.err, 1'b1);
    chk("t4_rej_last_done", ifa.done, 1'b0);
    push_a(2'd0, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    chk("t4_rej_last_nodone", ifa.done, 1'b0);
    pop_check("t4_pre",    r_word(1), 10'd0, 1'b0);
    pop_check("t4_reload", r_word(2), 10'd0, 1'b0);
    chk("t4_errcnt3", ifa.err_count, 8'd3);
    // saturation: 300 illegal bundles
    for (int k = 0; k < 252; k++) push_a(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1000, 1'b0);
    chk("t4_errcnt_255", ifa.err_count, 8'd255);
    for (int k = 0; k < 48; k++) push_a(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1000, 1'b0);
    chk("t4_errcnt_sat", ifa.err_count, 8'd255);
    chk("t4_sat_err",    ifa.err, 1'b1);
    chk("t4_sat_empty",  ifa.out_valid, 1'b0);

    // T5: ADDR_W=2 counter wraps
    for (int k = 0; k < 5; k++) begin
      ifb.in_rd = 5'(k);
      ifb.in_valid = 1'b1;
      @(negedge clk);
      ifb.in_valid = 1'b0;
      chk("t5_valid", ifb.out_valid, 1'b1);
      chk("t5_instr", ifb.out_instr, r_word(k));
      chk("t5_addr",  ifb.out_addr, t5_exp[k]);
    end
    @(negedge clk);

    // T6: async reset with three entries queued
    for (int k = 1; k < 4; k++) push_a(2'd0, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    chk("t6_pre_valid", ifa.out_valid, 1'b1);
    chk("t6_pre_addr",  ifa.out_addr, 10'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",  ifa.out_valid, 1'b0);
    chk("t6_rst_ready",  ifa.in_ready, 1'b0);
    chk("t6_rst_instr",  ifa.out_instr, 32'h0);
    chk("t6_rst_errcnt", ifa.err_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", ifa.in_ready, 1'b1);
    chk("t6_rel_valid", ifa.out_valid, 1'b0);
    @(negedge clk);
    push_a(2'd0, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    pop_check("t6_restart", r_word(8), 10'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
